frame_ram_arbiter: RTL and testbench
====================================

# frame_ram_arbiter

Shares the single-port 512×512×8 frame RAM between two requesters: port 0 is the halftone converter, which runs the grayscale fill and the error-diffusion read/write passes; port 1 is the host readback/streaming engine. The block provides per-access request/grant, lock-based atomic ownership so the 5-read/5-write diffusion sequence of one pixel is never interleaved, round-robin fairness between unlocked accesses, and tagged routing of read data back to the issuing requester.

## Interface
- ADDR_W, 18, RAM word address width (262144 pixels)
- DATA_W, 8, pixel width
- RD_LAT, 1, RAM read latency in cycles (≥1)
- MAX_LOCK, 64, maximum consecutive cycles one port may own the RAM under lock
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rN_req  in  1  port N (N=0,1) access request, held until granted
- rN_we  in  1  1 = write, 0 = read
- rN_lock  in  1  keep ownership after this access
- rN_addr  in  ADDR_W  access address
- rN_wdata  in  DATA_W  write data
- rN_gnt  out  1  access issued to RAM this cycle
- rN_rvalid  out  1  read data for port N valid
- rN_rdata  out  DATA_W  read data; ram_odata routed through
- ram_ren / ram_wen  out  1  RAM strobes, never both high
- ram_addr  out  ADDR_W;  ram_idata  out  DATA_W
- ram_odata  in  DATA_W  RAM read data
- owner  out  2  00 none, 01 port 0 locked, 10 port 1 locked
- lock_err  out  1  one-cycle pulse on lock timeout

## Operation
- States: IDLE (arbitrating), OWN0, OWN1. Reset → IDLE, last_gnt = 1, so port 0 wins the first contention.
- IDLE: a single requester is granted. If both request, the port ≠ last_gnt is granted. last_gnt updates on every grant.
- Granted access with rN_lock=1 → OWNN. Granted access with lock=0 → IDLE.
- OWNN: only port N may be granted, and the other port's req is ignored. Leave to IDLE when port N's granted access has lock=0, or when rN_req=0 and rN_lock=0 in the same cycle.
- Lock counter: cleared on entering OWNN, incremented each cycle in OWNN. When it reaches MAX_LOCK: lock_err pulses, state → IDLE, last_gnt = N. Any access granted that cycle completes normally.
- RAM drive: combinational mux of the granted port's addr/wdata. ram_wen = gnt & we. ram_ren = gnt & ~we. When no grant: strobes low, addr/idata 0.
- Read return: RD_LAT-deep shift register of {valid, port}. The tagged port sees rvalid when the entry exits the register. rdata of both ports = ram_odata. The rvalid of the non-tagged port is 0.
- Boundary pixels, where the converter suppresses neighbour accesses, need no special handling: a lock held with req=0 keeps ownership without issuing an access.

## Timing
- Reset values: all gnt, rvalid, ram_ren, ram_wen, lock_err = 0. Addr/data outputs = 0. owner = 00. Read pipe cleared.
- Grant is combinational from req and the registered state. The access is issued in the grant cycle, so grant latency is 0 when uncontended.
- Read data: rN_rvalid asserts exactly RD_LAT cycles after the granted read. Back-to-back reads are accepted every cycle.
- Ownership change takes effect the cycle after the deciding access. Max wait for an unlocked competitor is 1 access, or MAX_LOCK+1 cycles if the other port holds a lock.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset. Lock ownership is lost.

## Structure
- Shared package halftone_pkg: ADDR_W, DATA_W, IMG_W=512, owner encoding constants. The converter and streamer import the same package.
- Sub-module rd_return_pipe (RD_LAT-deep {valid,tag} shift register with async clear). Arbiter FSM, lock counter and muxes stay in frame_ram_arbiter.

## Test plan
- Reset, then r0 read at 0x00010 alone: gnt0 in the same cycle, ram_ren=1, ram_addr=0x00010; r0_rvalid 1 cycle later with ram_odata=0x5A → r0_rdata=0x5A; r1_rvalid=0.
- r0 and r1 request unlocked reads continuously for 6 cycles: grants alternate 0,1,0,1,0,1 starting with port 0; each rvalid is tagged correctly.
- r0 issues 5 locked reads then 5 writes, with the last write unlocked, while r1 requests throughout: r1 gets no grant until the cycle after the unlocked write; owner = 01 during the sequence.
- r0 holds lock=1, req=0 for 70 cycles with MAX_LOCK=64 while r1 requests: lock_err pulses at cycle 64, and r1 is granted the next cycle.
- r1 reads address 0x3FFFF with RD_LAT=3 and back-to-back reads: three rvalids on r1 on consecutive cycles, 3 cycles after each grant.
- rst_n asserted 1 cycle after a granted read: no rvalid after reset release; owner = 00; strobes = 0.

Source files
------------

// File: rtl/halftone_pkg.sv
// Shared constants for the halftone frame RAM path.
// Owner codes double as the arbiter state encoding.
package halftone_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 512;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_P0   = 2'b01;
    localparam logic [1:0] OWNER_P1   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = OWNER_NONE,
        ST_OWN0 = OWNER_P0,
        ST_OWN1 = OWNER_P1
    } arb_state_t;

    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [8:0] x,
        input logic [8:0] y
    );
        return ADDR_W'(int'(y) * IMG_W + int'(x));
    endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// Tracks in-flight RAM reads and which port issued them.
// Cleared asynchronously so reads in flight at reset never return.
module rd_return_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_tag,
    output logic out_valid,
    output logic out_tag
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_tag   = tag_q[RD_LAT-1];

endmodule

// File: rtl/frame_ram_arbiter.sv
// Two-port arbiter for the single-port frame RAM with lock-based
// atomic ownership, round-robin fairness and tagged read return.
module frame_ram_arbiter #(
    parameter int ADDR_W   = halftone_pkg::ADDR_W,
    parameter int DATA_W   = halftone_pkg::DATA_W,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_idata,
    input  logic [DATA_W-1:0] ram_odata,
    output logic [1:0]        owner,
    output logic              lock_err
);

    import halftone_pkg::*;

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    arb_state_t       state_q;
    logic             last_gnt_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic             gnt0;
    logic             gnt1;
    logic             timeout;
    logic             pipe_valid;
    logic             pipe_tag;

    // Last owned cycle: the owner may still issue, then ownership drops.
    assign timeout = (state_q != ST_IDLE) && (lock_cnt_q == CNT_LAST);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (r0_req && r1_req) begin
                    gnt0 = last_gnt_q;
                    gnt1 = ~last_gnt_q;
                end else begin
                    gnt0 = r0_req;
                    gnt1 = r1_req;
                end
            end
            ST_OWN0: gnt0 = r0_req;
            ST_OWN1: gnt1 = r1_req;
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            lock_cnt_q <= '0;
        end else begin
            if (gnt0) begin
                last_gnt_q <= 1'b0;
            end else if (gnt1) begin
                last_gnt_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    lock_cnt_q <= '0;
                    if (gnt0 && r0_lock) begin
                        state_q <= ST_OWN0;
                    end else if (gnt1 && r1_lock) begin
                        state_q <= ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    lock_cnt_q <= lock_cnt_q + CNT_W'(1);
                    if (timeout) begin
                        state_q    <= ST_IDLE;
                        last_gnt_q <= 1'b0;
                    end else if ((gnt0 && !r0_lock) ||
                                 (!r0_req && !r0_lock)) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_OWN1: begin
                    lock_cnt_q <= lock_cnt_q + CNT_W'(1);
                    if (timeout) begin
                        state_q    <= ST_IDLE;
                        last_gnt_q <= 1'b1;
                    end else if ((gnt1 && !r1_lock) ||
                                 (!r1_req && !r1_lock)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    lock_cnt_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_idata = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        if (gnt0) begin
            ram_addr  = r0_addr;
            ram_idata = r0_wdata;
            ram_ren   = ~r0_we;
            ram_wen   = r0_we;
        end else if (gnt1) begin
            ram_addr  = r1_addr;
            ram_idata = r1_wdata;
            ram_ren   = ~r1_we;
            ram_wen   = r1_we;
        end
    end

    rd_return_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (ram_ren),
        .in_tag   (gnt1),
        .out_valid(pipe_valid),
        .out_tag  (pipe_tag)
    );

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign r0_rvalid = pipe_valid & ~pipe_tag;
    assign r1_rvalid = pipe_valid & pipe_tag;
    assign r0_rdata  = ram_odata;
    assign r1_rdata  = ram_odata;
    assign owner     = state_q;
    assign lock_err  = timeout;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed checks of frame_ram_arbiter with RD_LAT=1 and RD_LAT=3 instances.
module tb_frame_ram_arbiter;

    localparam int AW = 18;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic          r0_req = 0, r0_we = 0, r0_lock = 0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r1_req = 0, r1_we = 0, r1_lock = 0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          ram_ren, ram_wen, lock_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_idata;
    logic [DW-1:0] ram_odata = 8'h5A;
    logic [1:0]    owner;

    logic          b_r0_req = 0, b_r0_we = 0, b_r0_lock = 0;
    logic [AW-1:0] b_r0_addr = '0;
    logic [DW-1:0] b_r0_wdata = '0;
    logic          b_r1_req = 0, b_r1_we = 0, b_r1_lock = 0;
    logic [AW-1:0] b_r1_addr = '0;
    logic [DW-1:0] b_r1_wdata = '0;
    logic          b_r0_gnt, b_r0_rvalid, b_r1_gnt, b_r1_rvalid;
    logic [DW-1:0] b_r0_rdata, b_r1_rdata;
    logic          b_ram_ren, b_ram_wen, b_lock_err;
    logic [AW-1:0] b_ram_addr;
    logic [DW-1:0] b_ram_idata;
    logic [DW-1:0] b_ram_odata = 8'hC3;
    logic [1:0]    b_owner;

    always #5 clk = ~clk;

    frame_ram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_LOCK(64)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_idata(ram_idata), .ram_odata(ram_odata),
        .owner(owner), .lock_err(lock_err)
    );

    frame_ram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_LOCK(64)
    ) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_lock(b_r0_lock),
        .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
        .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_lock(b_r1_lock),
        .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
        .ram_ren(b_ram_ren), .ram_wen(b_ram_wen), .ram_addr(b_ram_addr),
        .ram_idata(b_ram_idata), .ram_odata(b_ram_odata),
        .owner(b_owner), .lock_err(b_lock_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk("rst_gnt0", 32'(r0_gnt), 0);
        chk("rst_gnt1", 32'(r1_gnt), 0);
        chk("rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 0);
        chk("rst_strobes", 32'({ram_ren, ram_wen}), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_idata", 32'(ram_idata), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_lock_err", 32'(lock_err), 0);
        cyc();
        rst_n = 1'b1;

        // Single uncontended read
        cyc();
        r0_req = 1; r0_we = 0; r0_lock = 0; r0_addr = 18'h00010;
        #1;
        chk("t1_gnt0", 32'(r0_gnt), 1);
        chk("t1_gnt1", 32'(r1_gnt), 0);
        chk("t1_ren", 32'(ram_ren), 1);
        chk("t1_wen", 32'(ram_wen), 0);
        chk("t1_addr", 32'(ram_addr), 32'h10);
        cyc();
        r0_req = 0;
        #1;
        chk("t1_rvalid0", 32'(r0_rvalid), 1);
        chk("t1_rdata0", 32'(r0_rdata), 32'h5A);
        chk("t1_rvalid1", 32'(r1_rvalid), 0);
        chk("t1_ren_idle", 32'(ram_ren), 0);

        // Round-robin between continuous unlocked readers
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            cyc();
            r0_req = (i < 6); r0_addr = 18'h100;
            r1_req = (i < 6); r1_addr = 18'h200;
            #1;
            if (i < 6) begin
                chk($sformatf("rr_gnt0_%0d", i), 32'(r0_gnt),
                    32'((i % 2) == 0));
                chk($sformatf("rr_gnt1_%0d", i), 32'(r1_gnt),
                    32'((i % 2) == 1));
                chk($sformatf("rr_addr_%0d", i), 32'(ram_addr),
                    ((i % 2) == 0) ? 32'h100 : 32'h200);
            end
            if (i > 0) begin
                chk($sformatf("rr_rv0_%0d", i), 32'(r0_rvalid),
                    32'(((i - 1) % 2) == 0));
                chk($sformatf("rr_rv1_%0d", i), 32'(r1_rvalid),
                    32'(((i - 1) % 2) == 1));
            end
        end

        // Locked 5-read/5-write sequence on port 0, port 1 waiting
        for (int j = 0; j < 11; j++) begin
            cyc();
            r0_req = (j < 10); r0_we = (j >= 5); r0_lock = (j < 9);
            r0_addr = AW'(j); r0_wdata = DW'(8'h30 + j);
            r1_req = 1; r1_we = 0; r1_addr = 18'h2AAAA;
            #1;
            if (j < 10) begin
                chk($sformatf("lk_gnt0_%0d", j), 32'(r0_gnt), 1);
                chk($sformatf("lk_gnt1_%0d", j), 32'(r1_gnt), 0);
                chk($sformatf("lk_own_%0d", j), 32'(owner),
                    (j == 0) ? 32'h0 : 32'h1);
                chk($sformatf("lk_wen_%0d", j), 32'(ram_wen),
                    32'(j >= 5));
            end else begin
                chk("lk_gnt1_after", 32'(r1_gnt), 1);
                chk("lk_own_after", 32'(owner), 0);
                chk("lk_addr_after", 32'(ram_addr), 32'h2AAAA);
            end
            if (j == 7) chk("lk_idata", 32'(ram_idata), 32'h37);
        end

        // Lock held with no requests until the timeout releases it
        cyc();
        r0_req = 1; r0_we = 0; r0_lock = 1; r0_addr = 18'h00400;
        r1_req = 1;
        #1;
        chk("to_gnt0", 32'(r0_gnt), 1);
        for (int k = 1; k <= 65; k++) begin
            cyc();
            r0_req = 0; r0_lock = 1;
            #1;
            chk($sformatf("to_gnt1_%0d", k), 32'(r1_gnt), 32'(k == 65));
            if (k >= 62)
                chk($sformatf("to_err_%0d", k), 32'(lock_err),
                    32'(k == 64));
            if (k == 1 || k == 64 || k == 65)
                chk($sformatf("to_own_%0d", k), 32'(owner),
                    (k == 65) ? 32'h0 : 32'h1);
        end
        cyc();
        r0_lock = 0; r1_req = 0;
        #1;
        chk("to_err_clear", 32'(lock_err), 0);

        // Back-to-back reads with RD_LAT=3
        for (int c = 0; c < 7; c++) begin
            cyc();
            b_r1_req = (c < 3); b_r1_we = 0; b_r1_addr = 18'h3FFFF;
            #1;
            if (c < 3) begin
                chk($sformatf("l3_gnt1_%0d", c), 32'(b_r1_gnt), 1);
                chk($sformatf("l3_addr_%0d", c), 32'(b_ram_addr),
                    32'h3FFFF);
            end
            chk($sformatf("l3_rv1_%0d", c), 32'(b_r1_rvalid),
                32'(c >= 3 && c <= 5));
            chk($sformatf("l3_rv0_%0d", c), 32'(b_r0_rvalid), 0);
            if (c == 4) chk("l3_rdata", 32'(b_r1_rdata), 32'hC3);
        end

        // Reset while a read is in flight and port 0 owns the RAM
        cyc();
        r0_req = 1; r0_we = 0; r0_lock = 1; r0_addr = 18'h00020;
        b_r1_req = 1; b_r1_addr = 18'h00033;
        #1;
        chk("mr_gnt0", 32'(r0_gnt), 1);
        chk("mr_bgnt1", 32'(b_r1_gnt), 1);
        cyc();
        r0_req = 0; r0_lock = 0; b_r1_req = 0;
        chk("mr_own_before", 32'(owner), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_own_rst", 32'(owner), 0);
        chk("mr_rv0_rst", 32'(r0_rvalid), 0);
        cyc();
        rst_n = 1'b1;
        for (int m = 0; m < 4; m++) begin
            cyc();
            #1;
            chk($sformatf("mr_brv1_%0d", m), 32'(b_r1_rvalid), 0);
            chk($sformatf("mr_own_%0d", m), 32'(owner), 0);
            chk($sformatf("mr_strb_%0d", m),
                32'({ram_ren, ram_wen, b_ram_ren, b_ram_wen}), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
